// File: rtl/twid_round_sat.sv
// Rescales full-precision twiddle products to DATA_WIDTH: round-half-up, shift right by SHIFT,
// saturate, and stream out through a two-stage elastic valid/ready pipeline with a sticky clip counter.
module twid_round_sat #(
    parameter int DATA_WIDTH = 21,
    parameter int TWID_WIDTH = 16,
    parameter int SHIFT      = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [DATA_WIDTH+TWID_WIDTH:0]   in_r,
    input  logic signed [DATA_WIDTH+TWID_WIDTH:0]   in_i,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [DATA_WIDTH-1:0]            out_r,
    output logic signed [DATA_WIDTH-1:0]            out_i,
    output logic                                    out_sat,
    output logic        [CNT_WIDTH-1:0]             sat_cnt,
    input  logic                                    clr_cnt
);

    localparam int IN_W  = DATA_WIDTH + TWID_WIDTH + 1;
    localparam int RND_W = IN_W + 1 - SHIFT;

    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX =
        {{(RND_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN =
        {{(RND_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // One guard bit above the input keeps the half-LSB add from overflowing.
    function automatic logic signed [RND_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        sum = {x[IN_W-1], x} + HALF;
        return sum[IN_W:SHIFT];
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [RND_W-1:0] v);
        logic [DATA_WIDTH:0] res;
        res = {1'b0, v[DATA_WIDTH-1:0]};
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end
        return res;
    endfunction

    logic                           vld_p1_q, vld_p1_d;
    logic signed [RND_W-1:0]        r_p1_q, r_p1_d;
    logic signed [RND_W-1:0]        i_p1_q, i_p1_d;
    logic                           vld_p2_q, vld_p2_d;
    logic signed [DATA_WIDTH-1:0]   r_p2_q, r_p2_d;
    logic signed [DATA_WIDTH-1:0]   i_p2_q, i_p2_d;
    logic                           sat_p2_q, sat_p2_d;
    logic        [CNT_WIDTH-1:0]    sat_cnt_q, sat_cnt_d;
    logic                           s1_adv;
    logic        [DATA_WIDTH:0]     sat_r, sat_i;

    always_comb begin
        s1_adv   = !vld_p2_q || out_ready;
        in_ready = !vld_p1_q || s1_adv;
    end

    always_comb begin
        vld_p1_d  = vld_p1_q;
        r_p1_d    = r_p1_q;
        i_p1_d    = i_p1_q;
        vld_p2_d  = vld_p2_q;
        r_p2_d    = r_p2_q;
        i_p2_d    = i_p2_q;
        sat_p2_d  = sat_p2_q;
        sat_cnt_d = sat_cnt_q;
        sat_r     = saturate(r_p1_q);
        sat_i     = saturate(i_p1_q);

        // Stage 1: round and shift
        if (in_ready) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                r_p1_d = round_shift(in_r);
                i_p1_d = round_shift(in_i);
            end
        end

        // Stage 2: saturate
        if (s1_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                r_p2_d   = sat_r[DATA_WIDTH-1:0];
                i_p2_d   = sat_i[DATA_WIDTH-1:0];
                sat_p2_d = sat_r[DATA_WIDTH] | sat_i[DATA_WIDTH];
            end
        end

        if (clr_cnt) begin
            sat_cnt_d = '0;
        end else if (vld_p2_q && out_ready && sat_p2_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            r_p2_q    <= '0;
            i_p2_q    <= '0;
            sat_p2_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            r_p2_q    <= r_p2_d;
            i_p2_q    <= i_p2_d;
            sat_p2_q  <= sat_p2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Stage-1 data is qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        r_p1_q <= r_p1_d;
        i_p1_q <= i_p1_d;
    end

    assign out_valid = vld_p2_q;
    assign out_r     = r_p2_q;
    assign out_i     = i_p2_q;
    assign out_sat   = sat_p2_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_twid_round_sat.sv
// Bench for twid_round_sat: directed and random stimulus scored against an arithmetic model
// of round-half-up, shift and clamp, plus sat counter, backpressure hold and reset behaviour.
module tb_twid_round_sat;

    localparam int DW = 21;
    localparam int TW = 16;
    localparam int SH = 15;
    localparam int CW = 16;
    localparam int IW = DW + TW + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 in_valid, out_ready, clr_cnt;
    logic signed [IW-1:0] in_r, in_i;
    logic                 in_ready, out_valid, out_sat;
    logic signed [DW-1:0] out_r, out_i;
    logic        [CW-1:0] sat_cnt;
    logic                 in_ready2, out_valid2, out_sat2;
    logic signed [DW-1:0] out_r2, out_i2;
    logic        [1:0]    sat_cnt2;

    twid_round_sat #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .SHIFT(SH), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_sat(out_sat), .sat_cnt(sat_cnt), .clr_cnt(clr_cnt));

    twid_round_sat #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .SHIFT(SH), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_r(in_r), .in_i(in_i), .out_valid(out_valid2), .out_ready(out_ready),
        .out_r(out_r2), .out_i(out_i2), .out_sat(out_sat2), .sat_cnt(sat_cnt2), .clr_cnt(clr_cnt));

    typedef struct {
        longint r;
        longint i;
        bit     sat;
        int     acc;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    longint model_cnt, model_cnt2;
    bit     lat_chk, hold_prev, last_in_fire, last_out_fire;
    logic signed [DW-1:0] hold_r, hold_i;
    logic   hold_sat;
    longint cur_r, cur_i;
    longint bp_r[4], bp_i[4];
    int     k;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // floor((x + 2^(SH-1)) / 2^SH)
    function automatic longint mdl_round(input longint x);
        longint d, v, q;
        d = longint'(1) << SH;
        v = x + d / 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint mdl_clamp(input longint v, output bit s);
        longint hi, lo, res;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        s = 1'b0;
        res = v;
        if (v > hi) begin res = hi; s = 1'b1; end
        if (v < lo) begin res = lo; s = 1'b1; end
        return res;
    endfunction

    function automatic longint rnd_val();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 200000)) - 100000;
            1: begin
                v = (longint'(1) << 35) + longint'($urandom_range(0, 65536)) - 32768;
                if ($urandom_range(0, 1) == 1) v = -v - 1;
            end
            2: begin
                v = {$urandom, $urandom};
                v = (v <<< 26) >>> 26;
            end
            default: v = (longint'($urandom_range(0, 4000)) - 2000) * 32768 + 16384;
        endcase
        return v;
    endfunction

    task automatic drive(input longint r, input longint i);
        cur_r = r;
        cur_i = i;
        in_r  = IW'(r);
        in_i  = IW'(i);
    endtask

    // One clock: check state at negedge, update the model, return at posedge+1.
    task automatic step();
        exp_t e;
        bit   sr, si, sat_fire;
        @(negedge clk);
        chk("sat_cnt", sat_cnt, model_cnt);
        chk("sat_cnt_w2", sat_cnt2, model_cnt2);
        chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
        chk("in_ready_w2", in_ready2, (exp_q.size() < 2) || out_ready);
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_r", out_r, hold_r);
            chk("hold_i", out_i, hold_i);
            chk("hold_sat", out_sat, hold_sat);
        end
        last_out_fire = out_valid && out_ready;
        last_in_fire  = in_valid && in_ready;
        sat_fire = 1'b0;
        if (last_out_fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_r", out_r, e.r);
                chk("out_i", out_i, e.i);
                chk("out_sat", out_sat, e.sat);
                chk("out_valid_w2", out_valid2, 1);
                chk("out_r_w2", out_r2, e.r);
                chk("out_i_w2", out_i2, e.i);
                chk("out_sat_w2", out_sat2, e.sat);
                if (lat_chk) chk("latency", cyc - e.acc, 2);
                sat_fire = e.sat;
            end
        end
        if (clr_cnt) begin
            model_cnt  = 0;
            model_cnt2 = 0;
        end else if (sat_fire) begin
            if (model_cnt < (longint'(1) << CW) - 1) model_cnt++;
            if (model_cnt2 < 3) model_cnt2++;
        end
        if (last_in_fire) begin
            e.r   = mdl_clamp(mdl_round(cur_r), sr);
            e.i   = mdl_clamp(mdl_round(cur_i), si);
            e.sat = sr | si;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        hold_prev = out_valid && !out_ready;
        hold_r    = out_r;
        hold_i    = out_i;
        hold_sat  = out_sat;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input longint r, input longint i);
        int n;
        drive(r, i);
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) step();
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        in_r = '0; in_i = '0; cur_r = 0; cur_i = 0;
        model_cnt = 0; model_cnt2 = 0; lat_chk = 1'b0; hold_prev = 1'b0;
        hold_r = '0; hold_i = '0; hold_sat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Directed values: basic, rounding ties, saturation.
        lat_chk = 1'b1;
        send(98304, -98304);
        send(16384, -16384);
        send(16383, -16385);
        send((longint'(1) << 36) - 1, -(longint'(1) << 36));
        send((longint'(1) << 35) - 1, 0);
        drain();
        chk("sat_cnt_after_sat", sat_cnt, 2);

        // Back-to-back random stream at full rate.
        in_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            drive(rnd_val(), rnd_val());
            step();
            chk("stream_accept", last_in_fire, 1);
        end
        drain();

        // Backpressure: only two samples fit while out_ready is low.
        lat_chk = 1'b0;
        for (int n = 0; n < 4; n++) begin
            bp_r[n] = rnd_val() + n;
            bp_i[n] = rnd_val() - n;
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        k = 0;
        for (int n = 0; n < 6; n++) begin
            drive(bp_r[k], bp_i[k]);
            step();
            if (last_in_fire) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                drive(bp_r[k], bp_i[k]);
            end else begin
                in_valid = 1'b0;
            end
            step();
            chk("bp_no_gap", last_out_fire, 1);
            if (last_in_fire) k++;
        end
        drain();

        // Counter: clear wins over a coincident saturating handshake.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        lat_chk = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive((longint'(1) << 36) - 1 - n, 0);
            step();
        end
        in_valid = 1'b0;
        step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_coincide_fire", last_out_fire, 1);
        chk("cnt_clr_wins", sat_cnt, 0);
        drain();

        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            drive(-(longint'(1) << 36) + n, 7);
            step();
        end
        drain();
        chk("cnt_count5", sat_cnt, 5);
        chk("cnt_w2_sticks", sat_cnt2, 3);

        // Random traffic with random backpressure and clears.
        lat_chk = 1'b0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 24) == 0);
            drive(rnd_val(), rnd_val());
            step();
        end
        clr_cnt = 1'b0;
        drain();

        // Reset with two samples in flight.
        lat_chk = 1'b1;
        in_valid = 1'b1;
        drive(rnd_val(), rnd_val());
        step();
        drive((longint'(1) << 36) - 1, 5);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_out_i", out_i, 0);
        chk("midrst_out_sat", out_sat, 0);
        chk("midrst_sat_cnt", sat_cnt, 0);
        chk("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        model_cnt = 0;
        model_cnt2 = 0;
        hold_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(3 * 32768 + 100, -(5 * 32768));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
